// File: rtl/pio_bus_master.sv
// Bus initiator for the single-clock peripheral bus: runs write, read and poll commands.
// Latency: write resp at T+2, read resp at T+2+RD_LATENCY, poll (RD_LATENCY+2)/read, illegal at T+1.
// Backpressure: one command outstanding; req_ready only in IDLE, response held until resp_ready.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready/req_op/req_addr/req_wdata/req_mask   command channel
//   resp_valid/resp_ready/resp_rdata/resp_err                 response channel
//   bus_we/bus_addr/bus_wd/bus_rd                             peripheral bus
module pio_bus_master #(
    parameter int WIDTH      = 32,
    parameter int RD_LATENCY = 1,
    parameter int POLL_MAX   = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [WIDTH-1:0] req_mask,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_wd,
    input  logic [WIDTH-1:0] bus_rd
);

    localparam int PCW = $clog2(POLL_MAX + 1);
    localparam int LCW = $clog2(RD_LATENCY + 1);

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_POLL = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        ADDR,
        WAIT,
        CHECK,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] rd_q;
    logic [PCW-1:0]   poll_cnt;
    logic [PCW-1:0]   poll_cnt_inc;
    logic [LCW-1:0]   lat_cnt;
    logic             lat_done;
    logic             match;
    logic             poll_last;

    assign lat_done     = (lat_cnt == LCW'(RD_LATENCY - 1));
    // Only masked bits take part in the compare; mask=0 always matches.
    assign match        = (((rd_q ^ wdata_q) & mask_q) == '0);
    assign poll_cnt_inc = poll_cnt + PCW'(1);
    assign poll_last    = (poll_cnt_inc == PCW'(POLL_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        bus_we     = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    case (req_op)
                        OP_WR:   state_nxt = WRITE;
                        OP_RD:   state_nxt = ADDR;
                        OP_POLL: state_nxt = ADDR;
                        default: state_nxt = RESP;
                    endcase
                end
            end
            WRITE: begin
                bus_we    = 1'b1;
                state_nxt = RESP;
            end
            ADDR: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_done) begin
                    state_nxt = (op_q == OP_RD) ? RESP : CHECK;
                end
            end
            CHECK: begin
                state_nxt = (match || poll_last) ? RESP : ADDR;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_WR;
            wdata_q    <= '0;
            mask_q     <= '0;
            rd_q       <= '0;
            poll_cnt   <= '0;
            lat_cnt    <= '0;
            bus_addr   <= '0;
            bus_wd     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        wdata_q  <= req_wdata;
                        mask_q   <= req_mask;
                        poll_cnt <= '0;
                        // An illegal op must not disturb the bus, so the address is
                        // only taken for real bus commands.
                        if (req_op != 2'b11) begin
                            bus_addr <= req_addr;
                        end
                        if (req_op == OP_WR) begin
                            bus_wd <= req_wdata;
                        end
                        if (req_op == 2'b11) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                ADDR: begin
                    lat_cnt <= '0;
                end
                WAIT: begin
                    if (lat_done) begin
                        rd_q <= bus_rd;
                        if (op_q == OP_RD) begin
                            resp_rdata <= bus_rd;
                            resp_err   <= 1'b0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LCW'(1);
                    end
                end
                CHECK: begin
                    if (match) begin
                        resp_rdata <= rd_q;
                        resp_err   <= 1'b0;
                    end else begin
                        poll_cnt <= poll_cnt_inc;
                        if (poll_last) begin
                            resp_rdata <= rd_q;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_bus_master.sv
module tb_pio_bus_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_mask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wd;
    logic [31:0] bus_rd;

    int total;
    int bad;
    int cyc;
    int poll_sw;

    pio_bus_master #(
        .WIDTH(32),
        .RD_LATENCY(1),
        .POLL_MAX(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_mask(req_mask),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_wd(bus_wd),
        .bus_rd(bus_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder with one registered read cycle. Address 0x8 returns 0 until the
    // address cycle reaches poll_sw, then 3.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        case (bus_addr)
            32'h4:   bus_rd <= 32'h5;
            32'h8:   bus_rd <= (cyc >= poll_sw) ? 32'h3 : 32'h0;
            32'h10:  bus_rd <= 32'h77;
            default: bus_rd <= 32'h0;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Present a command at a negedge and return the acceptance cycle T.
    // Returns at the sampling point of cycle T+1.
    task automatic send(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mask,
                        input bit keep, output int t);
        int n;
        n = 0;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_mask  = mask;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready got=%b exp=1", req_ready);
        end
        t = cyc;
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
        req_addr  = 32'hDEAD_0000;
        req_wdata = 32'hFFFF_FFFF;
        req_mask  = 32'h0;
        @(negedge clk);
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL take_resp got=%b%b exp=01", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus_we, resp_valid, resp_err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctl got=%b%b%b exp=000", bus_we, resp_valid, resp_err);
        end
        total++;
        if (bus_addr !== 32'h0 || bus_wd !== 32'h0 || resp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", bus_addr, bus_wd, resp_rdata);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_write();
        int t;
        send(2'b00, 32'h0, 32'h2A, 32'h0, 1'b0, t);
        total++;
        if (bus_we !== 1'b1 || bus_addr !== 32'h0 || bus_wd !== 32'h2A) begin
            bad++;
            $display("FAIL write_bus got=%b/%h/%h exp=1/0/2a", bus_we, bus_addr, bus_wd);
        end
        wait_until(t + 2);
        total++;
        if (bus_we !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL write_resp got=we%b v%b %h e%b exp=we0 v1 0 e0",
                     bus_we, resp_valid, resp_rdata, resp_err);
        end
        take_resp();
    endtask

    task automatic test_read();
        int t;
        resp_ready = 1'b1;
        send(2'b01, 32'h4, 32'h0, 32'h0, 1'b0, t);
        total++;
        if (bus_addr !== 32'h4 || bus_we !== 1'b0 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_t1 got=%h we%b v%b exp=4 we0 v0", bus_addr, bus_we, resp_valid);
        end
        wait_until(t + 2);
        total++;
        if (bus_addr !== 32'h4 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_t2 got=%h v%b exp=4 v0", bus_addr, resp_valid);
        end
        wait_until(t + 3);
        total++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h5 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL read_resp got=v%b %h e%b exp=v1 5 e0", resp_valid, resp_rdata, resp_err);
        end
        wait_until(t + 4);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL read_onecycle got=v%b r%b exp=v0 r1", resp_valid, req_ready);
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_poll_match();
        int t;
        bit we_seen;
        we_seen = 1'b0;
        send(2'b10, 32'h8, 32'h1, 32'h1, 1'b0, t);
        // Reads 0..3 present their address in cycles T+1,4,7,10; read 4 in T+13.
        poll_sw = t + 11;
        while (cyc < t + 15) begin
            if (bus_we !== 1'b0) we_seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (resp_valid !== 1'b0 || we_seen !== 1'b0) begin
            bad++;
            $display("FAIL poll_early got=v%b we%b exp=v0 we0", resp_valid, we_seen);
        end
        wait_until(t + 16);
        total++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h3 || resp_err !== 1'b0 || bus_addr !== 32'h8) begin
            bad++;
            $display("FAIL poll_resp got=v%b %h e%b a%h exp=v1 3 e0 a8",
                     resp_valid, resp_rdata, resp_err, bus_addr);
        end
        poll_sw = 1000000;
        take_resp();
    endtask

    task automatic test_poll_mask0();
        int t;
        send(2'b10, 32'hC, 32'hFF, 32'h0, 1'b0, t);
        wait_until(t + 3);
        total++;
        if (resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL mask0_early got=%b exp=0", resp_valid);
        end
        wait_until(t + 4);
        total++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL mask0_resp got=v%b %h e%b exp=v1 0 e0", resp_valid, resp_rdata, resp_err);
        end
        take_resp();
    endtask

    task automatic test_poll_timeout();
        int t;
        bit rdy_seen;
        rdy_seen = 1'b0;
        send(2'b10, 32'hC, 32'h1, 32'h1, 1'b0, t);
        while (cyc < t + 25) begin
            if (req_ready !== 1'b0 || resp_valid !== 1'b0) rdy_seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (rdy_seen !== 1'b0) begin
            bad++;
            $display("FAIL timeout_busy got=%b exp=0", rdy_seen);
        end
        total++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL timeout_resp got=v%b e%b %h r%b exp=v1 e1 0 r0",
                     resp_valid, resp_err, resp_rdata, req_ready);
        end
        take_resp();
    endtask

    task automatic test_back_to_back();
        int t;
        // req_valid stays high with the next command (read 0x10) behind it.
        send(2'b01, 32'h4, 32'h0, 32'h0, 1'b1, t);
        req_op   = 2'b01;
        req_addr = 32'h10;
        wait_until(t + 2);
        total++;
        if (bus_addr !== 32'h4) begin
            bad++;
            $display("FAIL b2b_latch got=%h exp=4", bus_addr);
        end
        for (int k = 3; k <= 12; k++) begin
            wait_until(t + k);
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h5 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL b2b_hold_%0d got=v%b %h r%b exp=v1 5 r0",
                         k, resp_valid, resp_rdata, req_ready);
            end
        end
        wait_until(t + 13);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_notyet got=%b exp=0", req_ready);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready got=r%b v%b exp=r1 v0", req_ready, resp_valid);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_until(t + 17);
        total++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h77 || bus_addr !== 32'h10) begin
            bad++;
            $display("FAIL b2b_second got=v%b %h a%h exp=v1 77 a10", resp_valid, resp_rdata, bus_addr);
        end
        take_resp();
    endtask

    task automatic test_reset_mid();
        int t;
        bit stale;
        stale = 1'b0;
        send(2'b10, 32'hC, 32'h1, 32'h1, 1'b0, t);
        wait_until(t + 2);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus_we !== 1'b0 || resp_valid !== 1'b0 || bus_addr !== 32'h0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_now got=we%b v%b a%h r%b exp=we0 v0 a0 r1",
                     bus_we, resp_valid, bus_addr, req_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_ready got=%b exp=1", req_ready);
        end
        repeat (30) begin
            if (resp_valid !== 1'b0) stale = 1'b1;
            @(negedge clk);
        end
        total++;
        if (stale !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_stale got=%b exp=0", stale);
        end
        // Reset during the write strobe must drop bus_we straight away.
        send(2'b00, 32'h20, 32'h55, 32'h0, 1'b0, t);
        total++;
        if (bus_we !== 1'b1) begin
            bad++;
            $display("FAIL rstwr_pre got=%b exp=1", bus_we);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus_we !== 1'b0 || bus_wd !== 32'h0) begin
            bad++;
            $display("FAIL rstwr_now got=we%b %h exp=we0 0", bus_we, bus_wd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        int t;
        send(2'b11, 32'h99, 32'h1234, 32'h0, 1'b0, t);
        total++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL illegal_resp got=v%b e%b %h exp=v1 e1 0", resp_valid, resp_err, resp_rdata);
        end
        total++;
        if (bus_we !== 1'b0 || bus_addr !== 32'h0) begin
            bad++;
            $display("FAIL illegal_bus got=we%b a%h exp=we0 a0", bus_we, bus_addr);
        end
        take_resp();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        poll_sw    = 1000000;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_mask   = 32'h0;
        resp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_poll_match();
        test_poll_mask0();
        test_poll_timeout();
        test_back_to_back();
        test_reset_mid();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
